// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush (bubble insertion) and a saturating stall counter.
module pipe_skid_reg #(
  parameter int unsigned        DATA_W    = 104,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter bit                 SKID      = 1'b1,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [DATA_W-1:0] mainReg;
  logic [DATA_W-1:0] skidReg;
  logic              loadMain;
  logic              loadSkid;
  logic              mainFromSkid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // FULL is reachable only with SKID=1; in pass mode BUSY holds instead.
  always_comb begin
    nextState    = state;
    loadMain     = 1'b0;
    loadSkid     = 1'b0;
    mainFromSkid = 1'b0;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            nextState = BUSY;
            loadMain  = 1'b1;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            loadMain = 1'b1;
          end else if (in_valid && SKID) begin
            nextState = FULL;
            loadSkid  = 1'b1;
          end else if (!in_valid && out_ready) begin
            nextState = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            nextState    = BUSY;
            mainFromSkid = 1'b1;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  // Skid mode keeps in_ready a pure function of state: no out_ready->in_ready path.
  always_comb begin
    out_valid = (state != EMPTY);
    if (SKID) begin
      in_ready = (state != FULL);
    end else begin
      in_ready = (state == EMPTY) || out_ready;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mainReg <= RESET_VAL;
      skidReg <= RESET_VAL;
    end else if (flush) begin
      mainReg <= RESET_VAL;
      skidReg <= RESET_VAL;
    end else begin
      if (loadMain) begin
        mainReg <= in_data;
      end else if (mainFromSkid) begin
        mainReg <= skidReg;
      end
      if (loadSkid) begin
        skidReg <= in_data;
      end
    end
  end

  assign out_data = mainReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: skid mode, pass mode and a narrow-counter
// instance share one clock and reset, each with its own handshake signals.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         flush    [3];
  logic         inValid  [3];
  logic         inReady  [3];
  logic         outValid [3];
  logic         outReady [3];
  logic [103:0] inData   [3];
  logic [103:0] outData  [3];
  logic [15:0]  cnt1;
  logic [15:0]  cnt0;
  logic [3:0]   cnt4;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  logic [103:0] sb [3][$];
  int unsigned  stExp [3];
  logic [15:0]  savedCnt;

  // index 0: skid mode, index 1: pass mode, index 2: skid mode with 4-bit counter
  pipe_skid_reg u1 (
    .clk(clk), .reset(reset), .flush(flush[0]),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
    .stall_cnt(cnt1)
  );

  pipe_skid_reg #(.SKID(1'b0)) u0 (
    .clk(clk), .reset(reset), .flush(flush[1]),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
    .stall_cnt(cnt0)
  );

  pipe_skid_reg #(.CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .flush(flush[2]),
    .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]),
    .stall_cnt(cnt4)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned i, input logic v, input logic [103:0] d);
    inValid[i] = v;
    inData[i]  = d;
  endtask

  // Handshakes are stable between negedge and the following posedge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        sb[i].delete();
        stExp[i] = 0;
      end else begin
        if (outValid[i] && !outReady[i] && stExp[i] < ((i == 2) ? 15 : 65535))
          stExp[i]++;
        if (flush[i]) begin
          sb[i].delete();
        end else begin
          if (outValid[i] && outReady[i]) begin
            check($sformatf("emit_expected%0d", i), sb[i].size() != 0, 1);
            if (sb[i].size() != 0)
              check($sformatf("order%0d", i), outData[i], sb[i].pop_front());
          end
          if (inValid[i] && inReady[i])
            sb[i].push_back(inData[i]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush[i] = 1'b0; inValid[i] = 1'b0; inData[i] = '0; outReady[i] = 1'b0;
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_valid", outValid[0], 0);
    check("rst_ready", inReady[0], 1);

    // streaming, skid mode
    outReady[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1'b1, 104'(k));
      check("stream_rdy", inReady[0], 1);
      tick();
      check("stream_valid", outValid[0], 1);
      check("stream_data", outData[0], 104'(k));
    end
    drive(0, 1'b0, '0);
    tick();
    check("stream_drained", outValid[0], 0);
    check("stream_stall", cnt1, 0);

    // backpressure, skid mode
    outReady[0] = 1'b0;
    drive(0, 1'b1, 104'hA); tick();
    drive(0, 1'b1, 104'hB);
    check("bp_rdy_busy", inReady[0], 1);
    tick();
    check("bp_rdy_full", inReady[0], 0);
    check("bp_hold_a", outData[0], 104'hA);
    drive(0, 1'b1, 104'hC); tick(); tick();
    check("bp_still_full", inReady[0], 0);
    check("bp_still_a", outData[0], 104'hA);
    outReady[0] = 1'b1;
    tick();
    check("bp_b", outData[0], 104'hB);
    check("bp_rdy_back", inReady[0], 1);
    tick();
    check("bp_c", outData[0], 104'hC);
    drive(0, 1'b0, '0);
    tick();
    check("bp_empty", outValid[0], 0);
    check("bp_stall", cnt1, 3);
    check("bp_stall_model", cnt1, 16'(stExp[0]));

    // same stimulus, pass mode
    outReady[1] = 1'b0;
    drive(1, 1'b1, 104'hA);
    check("p_rdy_empty", inReady[1], 1);
    tick();
    drive(1, 1'b1, 104'hB);
    check("p_rdy_stall", inReady[1], 0);
    outReady[1] = 1'b1; #1;
    check("p_rdy_comb_hi", inReady[1], 1);
    outReady[1] = 1'b0; #1;
    check("p_rdy_comb_lo", inReady[1], 0);
    tick(); tick();
    check("p_hold_a", outData[1], 104'hA);
    outReady[1] = 1'b1;
    tick();
    check("p_b", outData[1], 104'hB);
    drive(1, 1'b1, 104'hC);
    tick();
    check("p_c", outData[1], 104'hC);
    drive(1, 1'b0, '0);
    tick();
    check("p_empty", outValid[1], 0);
    check("p_stall", cnt0, 2);

    // flush while full, skid mode
    outReady[0] = 1'b0;
    drive(0, 1'b1, 104'h11); tick();
    drive(0, 1'b1, 104'h22); tick();
    check("fl_full", inReady[0], 0);
    drive(0, 1'b1, 104'h55);
    flush[0] = 1'b1;
    outReady[0] = 1'b1;
    savedCnt = cnt1;
    tick();
    flush[0] = 1'b0;
    drive(0, 1'b0, '0);
    check("fl_valid", outValid[0], 0);
    check("fl_data", outData[0], 0);
    check("fl_stall", cnt1, savedCnt);
    tick(); tick(); tick();
    check("fl_no_emit", outValid[0], 0);
    drive(0, 1'b1, 104'h66); tick();
    check("fl_resume", outData[0], 104'h66);
    drive(0, 1'b0, '0); tick();

    // counter saturation, 4-bit counter
    outReady[2] = 1'b0;
    drive(2, 1'b1, 104'h7); tick();
    drive(2, 1'b0, '0);
    repeat (20) tick();
    check("sat_cnt", cnt4, 4'd15);
    check("sat_model", cnt4, 4'(stExp[2]));
    flush[2] = 1'b1; tick(); flush[2] = 1'b0;
    check("sat_after_flush", cnt4, 4'd15);
    check("sat_flush_valid", outValid[2], 0);

    // asynchronous reset mid-stream
    outReady[0] = 1'b0; outReady[1] = 1'b0;
    drive(0, 1'b1, 104'h77); drive(1, 1'b1, 104'h99); tick();
    drive(0, 1'b1, 104'h88); tick();
    drive(0, 1'b0, '0); drive(1, 1'b0, '0);
    reset = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ar_valid%0d", i), outValid[i], 0);
      check($sformatf("ar_data%0d", i), outData[i], 0);
      check($sformatf("ar_ready%0d", i), inReady[i], 1);
    end
    check("ar_cnt1", cnt1, 0);
    check("ar_cnt0", cnt0, 0);
    check("ar_cnt4", cnt4, 0);
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) outReady[i] = 1'b1;
    repeat (3) tick();
    check("ar_no_emit0", outValid[0], 0);
    check("ar_no_emit1", outValid[1], 0);

    for (int i = 0; i < 3; i++)
      check($sformatf("sb_drained%0d", i), sb[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
